riscv_muldiv_unit: RTL and testbench
====================================

Name: riscv_muldiv_unit

Overview:
- Iterative multi-cycle unit that executes the RISC-V M-extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU in the execute stage. Takes the same register operands and funct3, and drives a stall to the pipeline while it works.
- Generalises the ALU in two ways: operand width is set by the XLEN parameter, and multiply throughput is configurable.
- Adds a valid/ready request/response handshake and flush-abort behaviour.

Parameters:
- XLEN, 32, operand and result width. Must be 32 or 64.
- MUL_STEP, 1, multiplier bits retired per multiply iteration. Must be 1, 2, 4 or 8 and must divide XLEN.

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- reset  in  1  asynchronous active-low reset.
- req_valid  in  1  request present. Only valid when the instruction is OP with funct7=0000001.
- req_ready  out  1  unit can accept a request.
- funct3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- data_in1  in  XLEN  rs1 operand.
- data_in2  in  XLEN  rs2 operand.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- data_toReg  out  XLEN  result.
- busy  out  1  stall request to the pipeline.
- flush  in  1  pipeline flush; aborts the current operation.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - req_ready=1, resp_valid=0, data_toReg=0, busy=0.
  - Iteration counter and internal registers cleared.
  - Reset asserted mid-operation discards the operation with no response.
- Accept rule:
  - A request is accepted on a rising edge with req_valid&req_ready.
  - Operands and funct3 are latched on that edge. Inputs are ignored at all other times.
- req_ready=1 only in IDLE. busy = req_valid | (state!=IDLE).
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE transitions on accept:
  - Divide op with data_in2==0 → DONE in one cycle:
    - DIV/DIVU: result all-ones.
    - REM/REMU: result data_in1.
  - DIV/REM with data_in1 == most-negative value and data_in2 == all-ones → DONE in one cycle:
    - DIV: result data_in1.
    - REM: result 0.
  - Any other funct3[2]=0 → MUL.
  - Any other funct3[2]=1 → DIV.
- Operand conditioning at accept:
  - Signed operands are converted to magnitude.
  - Signs are recorded per operation:
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both operands signed.
    - MULHU, MUL, DIVU, REMU: unsigned.
- MUL state:
  - Shift-add, MUL_STEP bits per cycle.
  - 2*XLEN-bit product accumulator.
  - Runs NM = XLEN/MUL_STEP cycles, then → FIX.
- DIV state:
  - Restoring divide, one quotient bit per cycle.
  - Runs ND = XLEN cycles, then → FIX.
- FIX state (1 cycle): negate result if needed, select result, → DONE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MUL selects product[XLEN-1:0]; MULH/MULHSU/MULHU select product[2XLEN-1:XLEN].
- DONE state:
  - resp_valid=1 and data_toReg holds the result.
  - Both are held stable until resp_ready=1.
  - The edge with resp_ready=1 → IDLE, with resp_valid=0 after that edge.
  - No new request is accepted in the same cycle.
- Latency, with accept on edge 0:
  - resp_valid is first high after edge N+1, where N=NM or ND.
  - XLEN=32, MUL_STEP=1: edge 33 for both MUL and DIV.
  - MUL_STEP=4: MUL on edge 9.
  - Special-case divides: edge 1.
- Flush:
  - flush=1 on an edge in any state → IDLE.
  - resp_valid=0 after that edge; the result is discarded.
  - flush outranks accept and resp_ready in the same cycle.
  - flush in IDLE with req_valid=1: the request is not accepted.
- Arithmetic:
  - All results are modulo 2^XLEN.
  - The magnitude of the most-negative value is handled as unsigned XLEN bits, with no overflow.
- data_toReg = 0 whenever resp_valid=0.

Test Plan:
- XLEN=32, MUL_STEP=1. MUL 7×6: resp_valid after edge 33, data_toReg=0x0000002A. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU of the same operands → 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF, rs2=0x00000002 → 0xFFFFFFFF. Repeat with MUL_STEP=4: resp_valid after edge 9, same result.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each has resp_valid after edge 33.
- DIVU 5/0 → 0xFFFFFFFF. REM 0x80000000 % 0xFFFFFFFF → 0. DIV of the same operands → 0x80000000. Each has resp_valid after edge 1.
- Backpressure: hold resp_ready=0 for 5 cycles after DONE → resp_valid and data stay stable, req_ready=0, busy=1. Assert resp_ready=1 → IDLE on the next edge.
- Flush on edge 10 of a DIV → IDLE, no response, req_ready=1. Assert reset low on edge 12 of a MUL → outputs return to reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply (MUL_STEP bits/cycle) and
// restoring divide (1 bit/cycle), with valid/ready handshake and flush abort.
module riscv_muldiv_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data_in1,
    input  logic [XLEN-1:0] data_in2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] data_toReg,
    output logic            busy,
    input  logic            flush
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned NM = XLEN / MUL_STEP;
    localparam int unsigned PW = XLEN + MUL_STEP;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                special_q, special_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                accept, sgn1, sgn2, div_zero, div_ovf;
    logic [XLEN-1:0]     mag1, mag2;
    logic [PW-1:0]       pp, mul_sum;
    logic [XLEN:0]       rem_shift, rem_sub;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

    assign req_ready  = (state_q == StIdle);
    assign busy       = req_valid | (state_q != StIdle);
    assign resp_valid = (state_q == StDone);
    assign data_toReg = resp_valid ? res_q : '0;
    assign accept     = req_valid & req_ready & ~flush;

    // Signed operands: MULH/MULHSU/DIV/REM for rs1, MULH/DIV/REM for rs2.
    assign sgn1 = data_in1[XLEN-1] & ((funct3[2] & ~funct3[0]) |
                  (~funct3[2] & (funct3[1] ^ funct3[0])));
    assign sgn2 = data_in2[XLEN-1] & ((funct3[2] & ~funct3[0]) | (funct3 == 3'b001));
    assign mag1 = sgn1 ? -data_in1 : data_in1;
    assign mag2 = sgn2 ? -data_in2 : data_in2;

    assign div_zero = funct3[2] & (data_in2 == '0);
    assign div_ovf  = funct3[2] & ~funct3[0] & (data_in1 == MinNeg) & (data_in2 == '1);

    // Right-shifting accumulator: add partial product into the high half, then shift.
    assign pp      = {{MUL_STEP{1'b0}}, b_q} * {{XLEN{1'b0}}, a_q[MUL_STEP-1:0]};
    assign mul_sum = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;

    // rem_sub[XLEN] set means the trial subtraction borrowed, so restore.
    assign rem_shift = {acc_q[XLEN-1:0], a_q[XLEN-1]};
    assign rem_sub   = rem_shift - {1'b0, b_q};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -a_q : a_q;
    assign rem_fix  = neg_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    always_comb begin
        fix_res = '0;
        if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        special_d = special_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        res_d     = res_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = funct3;
                    a_d       = mag1;
                    b_d       = mag2;
                    acc_d     = '0;
                    neg_res_d = sgn1 ^ sgn2;
                    neg_rem_d = sgn1;
                    special_d = 1'b0;
                    res_d     = '0;
                    if (div_zero) begin
                        special_d = 1'b1;
                        res_d     = funct3[1] ? data_in1 : '1;
                        state_d   = StFix;
                    end else if (div_ovf) begin
                        special_d = 1'b1;
                        res_d     = funct3[1] ? '0 : data_in1;
                        state_d   = StFix;
                    end else if (funct3[2]) begin
                        cnt_d   = CW'(XLEN - 1);
                        state_d = StDiv;
                    end else begin
                        cnt_d   = CW'(NM - 1);
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[XLEN-1:MUL_STEP]};
                a_d   = a_q >> MUL_STEP;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end
            StDiv: begin
                a_d   = {a_q[XLEN-2:0], ~rem_sub[XLEN]};
                acc_d = {acc_q[2*XLEN-1:XLEN],
                         rem_sub[XLEN] ? rem_shift[XLEN-1:0] : rem_sub[XLEN-1:0]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end
            StFix: begin
                if (!special_q) res_d = fix_res;
                state_d = StDone;
            end
            StDone: begin
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            special_q <= special_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
        end
    end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: XLEN=32 with MUL_STEP=1 and MUL_STEP=4 instances.
module tb_riscv_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_valid4 = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] data_in1 = '0, data_in2 = '0;
    logic        resp_ready = 1'b1;
    logic        flush = 1'b0;
    logic        req_ready, resp_valid, busy;
    logic        req_ready4, resp_valid4, busy4;
    logic [31:0] data_toReg, data4;

    int checks = 0, errors = 0;
    int edge_n = 0, resp_cnt = 0;
    int acc_edge, saved;

    logic [31:0] exp_d[$], exp4_d[$];
    int          exp_e[$], exp4_e[$];
    string       exp_n[$], exp4_n[$];

    riscv_muldiv_unit #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .data_in1(data_in1), .data_in2(data_in2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .data_toReg(data_toReg),
        .busy(busy), .flush(flush)
    );

    riscv_muldiv_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
        .funct3(funct3), .data_in1(data_in1), .data_in2(data_in2),
        .resp_valid(resp_valid4), .resp_ready(resp_ready), .data_toReg(data4),
        .busy(busy4), .flush(flush)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor for the MUL_STEP=1 instance.
    initial begin
        bit seen;
        string nm;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_valid && !seen) begin
                seen = 1'b1;
                resp_cnt++;
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %h required no response", data_toReg);
                end else begin
                    nm = exp_n.pop_front();
                    check({nm, " data"}, data_toReg, exp_d.pop_front());
                    check({nm, " edge"}, edge_n, exp_e.pop_front());
                end
            end else if (!resp_valid) begin
                seen = 1'b0;
            end
        end
    end

    // Monitor for the MUL_STEP=4 instance.
    initial begin
        bit seen;
        string nm;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_valid4 && !seen) begin
                seen = 1'b1;
                if (exp4_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp4: got %h required no response", data4);
                end else begin
                    nm = exp4_n.pop_front();
                    check({nm, " data"}, data4, exp4_d.pop_front());
                    check({nm, " edge"}, edge_n, exp4_e.pop_front());
                end
            end else if (!resp_valid4) begin
                seen = 1'b0;
            end
        end
    end

    task automatic send(input bit use4, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input string nm, input bit push, output int edge_at);
        int n;
        n = 0;
        edge_at = -1;
        @(negedge clk);
        while (!(use4 ? req_ready4 : req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s: req_ready got 0 required 1", nm);
            return;
        end
        funct3   = f;
        data_in1 = a;
        data_in2 = b;
        if (use4) req_valid4 = 1'b1;
        else req_valid = 1'b1;
        @(posedge clk);
        #1;
        edge_at    = edge_n;
        req_valid  = 1'b0;
        req_valid4 = 1'b0;
        if (push) begin
            if (use4) begin
                exp4_d.push_back(exp); exp4_e.push_back(edge_at + lat); exp4_n.push_back(nm);
            end else begin
                exp_d.push_back(exp); exp_e.push_back(edge_at + lat); exp_n.push_back(nm);
            end
        end
    endtask

    task automatic wait_empty(input bit use4, input string nm);
        for (int i = 0; i < 100; i++) begin
            if ((use4 ? exp4_d.size() : exp_d.size()) == 0) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s: response timeout, got none required one", nm);
        exp_d.delete(); exp_e.delete(); exp_n.delete();
        exp4_d.delete(); exp4_e.delete(); exp4_n.delete();
    endtask

    task automatic op(input bit use4, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat,
                      input string nm);
        int e;
        send(use4, f, a, b, exp, lat, nm, 1'b1, e);
        wait_empty(use4, nm);
    endtask

    initial begin
        #23;
        check("rst req_ready", req_ready, 1);
        check("rst resp_valid", resp_valid, 0);
        check("rst data", data_toReg, 0);
        check("rst busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        op(0, 3'b000, 32'd7,        32'd6,        32'h0000002A, 33, "mul 7x6");
        op(0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh -1x-1");
        op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
        op(0, 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, "mulhsu");
        op(0, 3'b000, 32'h80000000, 32'd3,        32'h80000000, 33, "mul minneg x3");
        op(0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh minneg^2");
        op(0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div -7/2");
        op(0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem -7/2");
        op(0, 3'b101, 32'd100,      32'd7,        32'd14,       33, "divu 100/7");
        op(0, 3'b111, 32'd100,      32'd7,        32'd2,        33, "remu 100/7");
        op(0, 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div 7/-2");
        op(0, 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, "rem 7/-2");
        op(0, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu 5/0");
        op(0, 3'b111, 32'd5,        32'd0,        32'd5,        1,  "remu 5/0");
        op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem ovf");
        op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div ovf");
        op(1, 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 9,  "mulhsu step4");
        op(1, 3'b000, 32'd7,        32'd6,        32'h0000002A, 9,  "mul step4");

        // Backpressure: result must hold until resp_ready, and no accept on the release edge.
        resp_ready = 1'b0;
        op(0, 3'b101, 32'd100, 32'd7, 32'd14, 33, "bp divu");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp resp_valid", resp_valid, 1);
            check("bp data", data_toReg, 32'd14);
            check("bp req_ready", req_ready, 0);
            check("bp busy", busy, 1);
        end
        resp_ready = 1'b1;
        funct3     = 3'b000;
        data_in1   = 32'd1;
        data_in2   = 32'd1;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp release resp_valid", resp_valid, 0);
        check("bp release req_ready", req_ready, 1);
        check("bp release data", data_toReg, 0);

        // Flush on edge 10 of a divide.
        saved = resp_cnt;
        send(0, 3'b100, 32'd1000, 32'd3, 32'd0, 0, "flush div", 1'b0, acc_edge);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush edge", edge_n - acc_edge, 10);
        check("flush req_ready", req_ready, 1);
        check("flush resp_valid", resp_valid, 0);
        // Flush outranks a request in IDLE.
        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush idle req_ready", req_ready, 1);
        repeat (40) @(negedge clk);
        check("flush no resp", resp_cnt, saved);

        // Asynchronous reset during a multiply.
        send(0, 3'b000, 32'd9, 32'd9, 32'd0, 0, "reset mul", 1'b0, acc_edge);
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst req_ready", req_ready, 1);
        check("arst resp_valid", resp_valid, 0);
        check("arst data", data_toReg, 0);
        check("arst busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("arst no resp", resp_cnt, saved);

        op(0, 3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 33, "mulhu after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout required finish");
        $fatal(1, "timeout");
    end
endmodule
